fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the decode/control path: it owns the fetch program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned words in a small prefetch queue. Decode consumes `{id_pc, id_instr}` through a valid/ready handshake. Branch/jump resolution redirects the stream via `redirect`/`redirect_pc`, which flushes all buffered and in-flight instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; low 2 bits must be 0.
- `DEPTH`, default 2: prefetch queue entries, legal range 2..8.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `imem_req` output 1: read request; held high until acknowledged.
- `imem_addr` output [0:31]: byte address of request, word-aligned, stable while `imem_req` high.
- `imem_ack` input 1: request accepted and `imem_rdata` valid this cycle; ignored when `imem_req` low.
- `imem_rdata` input [0:31]: instruction word, sampled on edge where `imem_req && imem_ack`.
- `redirect` input 1: one-cycle pulse, restart fetch at `redirect_pc`.
- `redirect_pc` input [0:31]: new fetch address; bits [30:31] ignored (forced to 00).
- `id_valid` output 1: queue head holds a valid instruction.
- `id_ready` input 1: decode accepts head this cycle.
- `id_instr` output [0:31]: head instruction word.
- `id_pc` output [0:31]: address of head instruction.
- All vectors are declared [0:N-1], bit 0 = MSB, matching the datapath.

## Operation
- State: `fpc` (next fetch address), queue of DEPTH `{pc, instr}` entries with `count`, FSM `IDLE`/`WAIT`/`DISCARD`.
- `imem_req` = 1 in WAIT and DISCARD, 0 in IDLE. `imem_addr` = `fpc` in WAIT, the stale (pre-redirect) address in DISCARD.
- pop = `id_valid && id_ready && !redirect`; `space` = (count − pop) < DEPTH.
- IDLE: if `space` → WAIT.
- WAIT, no ack: stay; address unchanged.
- WAIT, ack: push `{fpc, imem_rdata}`; fpc += 4 (32-bit wrap, FFFF_FFFC → 0000_0000); stay WAIT if (count + 1 − pop) < DEPTH, else IDLE.
- DISCARD, no ack: stay. DISCARD, ack: drop data, → IDLE (fpc already holds redirect target).
- Redirect (highest priority, any state): count ← 0, no push, no pop, fpc ← `{redirect_pc[0:29], 2'b00}`; WAIT → DISCARD (in-flight request cannot be withdrawn); DISCARD stays DISCARD; IDLE stays IDLE. If redirect coincides with ack in WAIT, the returned word is dropped and state → IDLE (request already completed).
- Push and pop in same cycle: count unchanged, order preserved (FIFO).
- Queue never overflows: a request is only issued/kept when a slot is guaranteed.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `id_valid`=0, `id_instr`=0, `id_pc`=0, fpc=RESET_PC, count=0, state=IDLE.
- After reset deasserts: first edge IDLE→WAIT; `imem_req` high in cycle 1.
- Zero-wait memory (ack in same cycle as req): word pushed on that edge, `id_valid` high next cycle; sustained throughput 1 instruction/cycle with `id_ready` held high.
- N wait cycles: ack N cycles after req rises; throughput 1 per (N+1) cycles.
- Fetch-to-decode latency: 1 cycle after the acknowledging edge.
- Redirect: first post-redirect request issued 1 cycle after redirect if IDLE; 1 cycle after pending ack if DISCARD. `id_valid` low from the cycle after redirect until first new word is pushed.
- `id_instr`/`id_pc` hold stable while `id_valid && !id_ready`.
- Reset mid-operation: outputs return to reset values immediately, pending request abandoned.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning word = address, `id_ready`=1 → `id_pc` = 0,4,8,… on consecutive cycles, first `id_valid` at cycle 2.
- 2-cycle-wait memory → `imem_addr` stable across wait cycles; one instruction every 3 cycles; no duplicates or skips.
- `id_ready`=0 for 10 cycles, DEPTH=2 → exactly 2 entries buffered, `imem_req` drops, head holds pc 0; release → 0,4,8 delivered in order.
- Redirect to 0x0000_0103 while request to 0x10 is in flight → DISCARD, 0x10 word dropped, next `imem_addr`=0x0000_0100, next `id_pc`=0x100, queue flushed.
- Redirect coinciding with ack and pop → nothing pushed or popped, count=0, next request at redirect target.
- fpc=0xFFFF_FFFC fetched → next `imem_addr`=0x0000_0000; async reset asserted mid-WAIT → `imem_req`,`id_valid` low before next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage upstream of decode.
// Owns the fetch PC, issues word reads to instruction memory over a req/ack
// handshake and buffers returned words in a DEPTH-entry prefetch FIFO that
// decode drains through a valid/ready handshake. A redirect pulse flushes the
// FIFO and restarts fetch at redirect_pc.
//
// Ports:
//   clk, reset            single clock, async active-high reset
//   imem_req/imem_addr    read request and word-aligned byte address (out)
//   imem_ack/imem_rdata   request accepted, instruction word (in)
//   redirect/redirect_pc  restart pulse and new fetch address (in)
//   id_valid/id_ready     decode handshake; id_instr/id_pc are the FIFO head
//
// state   | meaning
// IDLE    | no request outstanding; waits for a guaranteed FIFO slot
// WAIT    | request at fpc outstanding; data is pushed on ack
// DISCARD | pre-redirect request still outstanding; its data is dropped
module fetch_unit #(
  parameter logic [0:31] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_rdata,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [0:31] id_instr,
  output logic [0:31] id_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q;
  logic [0:31]   fpc_q;
  logic [0:31]   stale_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] count_q;
  logic [0:31]   pc_mem_q    [DEPTH];
  logic [0:31]   instr_mem_q [DEPTH];

  logic          pop;
  logic          push;
  logic [CW:0]   occ_pop;
  logic [CW:0]   occ_push_pop;
  logic          space;
  logic          room_after_push;
  logic [0:31]   redirect_tgt;

  // The two low address bits of redirect_pc are dropped by design.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[30:31]};

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redirect_tgt    = {redirect_pc[0:29], 2'b00};
  assign pop             = id_valid && id_ready && !redirect;
  assign push            = (state_q == WAIT) && imem_ack && !redirect;
  assign occ_pop         = {1'b0, count_q} - {{CW{1'b0}}, pop};
  assign occ_push_pop    = occ_pop + {{CW{1'b0}}, 1'b1};
  assign space           = occ_pop < (CW+1)'(DEPTH);
  assign room_after_push = occ_push_pop < (CW+1)'(DEPTH);

  assign imem_req  = (state_q != IDLE);
  // In DISCARD fpc already holds the redirect target, so the in-flight
  // address is presented from the captured copy.
  assign imem_addr = (state_q == DISCARD) ? stale_q : fpc_q;
  assign id_valid  = (count_q != '0);
  assign id_instr  = instr_mem_q[rd_q];
  assign id_pc     = pc_mem_q[rd_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      stale_q <= RESET_PC;
    end else if (redirect) begin
      fpc_q <= redirect_tgt;
      case (state_q)
        IDLE: state_q <= IDLE;
        WAIT: begin
          // An ack on this edge completes the request; otherwise it must
          // still be waited out.
          if (imem_ack) begin
            state_q <= IDLE;
          end else begin
            state_q <= DISCARD;
            stale_q <= fpc_q;
          end
        end
        DISCARD: state_q <= imem_ack ? IDLE : DISCARD;
        default: state_q <= IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (space) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_ack) begin
            fpc_q   <= fpc_q + 32'd4;
            state_q <= room_after_push ? WAIT : IDLE;
          end
        end
        DISCARD: begin
          if (imem_ack) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (redirect) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wr_q]    <= fpc_q;
        instr_mem_q[wr_q] <= imem_rdata;
        wr_q              <= next_ptr(wr_q);
      end
      if (pop) rd_q <= next_ptr(rd_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

endmodule
